// File: rtl/bbox_msg_pkg.sv
// Shared constants, field positions and types for the bounding-box message reader.
// Contents: slave register map, status/message field positions, default IDs,
// FSM state enum and the decoded box payload.
package bbox_msg_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned COORD_W   = 11;
    localparam int unsigned MSG_CNT_W = 16;
    localparam int unsigned ERR_CNT_W = 8;

    // Slave register map
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MSG    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_ID     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_BBCOL  = 3'd3;

    // Status register: flush control bit and FIFO word-count field
    localparam int unsigned STATUS_FLUSH_BIT = 4;
    localparam logic [DATA_W-1:0] FLUSH_WORD = DATA_W'(1) << STATUS_FLUSH_BIT;
    localparam int unsigned WORDS_LSB = 8;
    localparam int unsigned WORDS_MSB = 15;
    localparam int unsigned WORDS_W   = WORDS_MSB - WORDS_LSB + 1;

    localparam logic [DATA_W-1:0] MSG_ID_DEFAULT    = 32'h0052_4242;
    localparam logic [DATA_W-1:0] EXPECT_ID_DEFAULT = 32'h1234_EEE2;

    // Coordinate packing inside a message word
    localparam int unsigned X_LSB = 16;
    localparam int unsigned X_MSB = 26;
    localparam int unsigned Y_LSB = 0;
    localparam int unsigned Y_MSB = 10;

    localparam int unsigned MSG_WORDS = 3;

    typedef enum logic [3:0] {
        S_ID_RD,
        S_ID_WAIT,
        S_FLUSH,
        S_IDLE,
        S_STAT_RD,
        S_STAT_WAIT,
        S_MSG_RD,
        S_MSG_WAIT,
        S_GAP,
        S_OUT,
        S_HALT
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] top;
        logic [COORD_W-1:0] right;
        logic [COORD_W-1:0] bottom;
    } box_t;

endpackage

// File: rtl/bbox_msg_reader_if.sv
// Avalon-MM master bus plus the decoded-box valid/ready stream.
// master: reader side (drives m_* strobes/address/data and box_*; receives
//         m_readdata and box_ready). slave: the image slave + box consumer.
interface bbox_msg_reader_if;
    import bbox_msg_pkg::*;

    logic                m_chipselect;
    logic                m_read;
    logic                m_write;
    logic [ADDR_W-1:0]   m_address;
    logic [DATA_W-1:0]   m_writedata;
    logic [DATA_W-1:0]   m_readdata;

    logic                box_valid;
    logic                box_ready;
    logic [COORD_W-1:0]  box_left;
    logic [COORD_W-1:0]  box_top;
    logic [COORD_W-1:0]  box_right;
    logic [COORD_W-1:0]  box_bottom;
    logic                box_empty;

    modport master (
        output m_chipselect, m_read, m_write, m_address, m_writedata,
        input  m_readdata,
        output box_valid, box_left, box_top, box_right, box_bottom, box_empty,
        input  box_ready
    );

    modport slave (
        input  m_chipselect, m_read, m_write, m_address, m_writedata,
        output m_readdata,
        input  box_valid, box_left, box_top, box_right, box_bottom, box_empty,
        output box_ready
    );
endinterface

// File: rtl/bbox_msg_reader_mm_read_strobe.sv
// Single-access Avalon-MM sequencer: turns a request into a one-cycle
// registered read or write strobe and refuses new requests while a strobe is
// on the bus, which guarantees an idle cycle between strobes.
// Ports: clk, reset_n; req_i/we_i/addr_i/wdata_i request; busy_o strobe on
// bus; rvalid_o read data valid this cycle, rdata_c_o read data; m_* bus.
module mm_read_strobe
    import bbox_msg_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_c_o,
    output logic              m_chipselect_o,
    output logic              m_read_o,
    output logic              m_write_o,
    output logic [ADDR_W-1:0] m_address_o,
    output logic [DATA_W-1:0] m_writedata_o,
    input  logic [DATA_W-1:0] m_readdata_i
);

    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              cs_q, cs_d;
    logic              rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Launch a strobe only when the bus was idle last cycle
    always_comb begin
        read_d   = 1'b0;
        write_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = read_q;
        if (req_i && !(read_q || write_q)) begin
            read_d  = !we_i;
            write_d = we_i;
            addr_d  = addr_i;
            if (we_i) begin
                wdata_d = wdata_i;
            end
        end
        cs_d = read_d || write_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            cs_q     <= 1'b0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            read_q   <= read_d;
            write_q  <= write_d;
            cs_q     <= cs_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy_o         = read_q || write_q;
    assign rvalid_o       = rvalid_q;
    assign rdata_c_o      = m_readdata_i;
    assign m_chipselect_o = cs_q;
    assign m_read_o       = read_q;
    assign m_write_o      = write_q;
    assign m_address_o    = addr_q;
    assign m_writedata_o  = wdata_q;

endmodule

// File: rtl/bbox_msg_reader.sv
// Hardware reader for the image slave's bounding-box message FIFO: checks the
// slave ID, flushes the FIFO, polls the word count, reads 3-word "RBB"
// messages and presents decoded boxes on a valid/ready stream.
// Ports: clk, reset_n (async, active-low); enable (0 parks in idle between
// messages); bus (Avalon master + box stream); msg_count, err_count, id_error.
module bbox_msg_reader
    import bbox_msg_pkg::*;
#(
    parameter int unsigned       POLL_CYCLES = 1000,
    parameter logic [DATA_W-1:0] EXPECT_ID   = EXPECT_ID_DEFAULT,
    parameter logic [DATA_W-1:0] MSG_ID      = MSG_ID_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    bbox_msg_reader_if.master    bus,
    output logic [MSG_CNT_W-1:0] msg_count,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 id_error
);

    localparam int unsigned TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [1:0]           idx_q, idx_d;
    box_t                 box_q, box_d;
    logic                 box_valid_q, box_valid_d;
    logic                 box_empty_q, box_empty_d;
    logic [MSG_CNT_W-1:0] msg_count_q, msg_count_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 id_error_q, id_error_d;

    logic                 acc_req_c, acc_we_c;
    logic [ADDR_W-1:0]    acc_addr_c;
    logic [DATA_W-1:0]    acc_wdata_c;
    logic                 acc_busy, acc_rvalid;
    logic [DATA_W-1:0]    acc_rdata_c;
    logic                 poll_done_c;

    mm_read_strobe u_strobe (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_i          (acc_req_c),
        .we_i           (acc_we_c),
        .addr_i         (acc_addr_c),
        .wdata_i        (acc_wdata_c),
        .busy_o         (acc_busy),
        .rvalid_o       (acc_rvalid),
        .rdata_c_o      (acc_rdata_c),
        .m_chipselect_o (bus.m_chipselect),
        .m_read_o       (bus.m_read),
        .m_write_o      (bus.m_write),
        .m_address_o    (bus.m_address),
        .m_writedata_o  (bus.m_writedata),
        .m_readdata_i   (bus.m_readdata)
    );

    assign poll_done_c = (timer_q == TMR_W'(POLL_CYCLES - 1));

    // Next-state, datapath and bus-request logic.
    // *_RD / S_FLUSH are the cycles in which the strobe is on the bus; the
    // request is raised on entry so the registered strobe lines up with the state.
    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        idx_d       = idx_q;
        box_d       = box_q;
        box_valid_d = box_valid_q;
        box_empty_d = box_empty_q;
        msg_count_d = msg_count_q;
        err_count_d = err_count_q;
        id_error_d  = id_error_q;
        acc_req_c   = 1'b0;
        acc_we_c    = 1'b0;
        acc_addr_c  = ADDR_STATUS;
        acc_wdata_c = '0;

        case (state_q)
            S_ID_RD: begin
                if (acc_busy) state_d = S_ID_WAIT;
            end
            S_ID_WAIT: begin
                if (acc_rvalid) begin
                    if (acc_rdata_c != EXPECT_ID) begin
                        id_error_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (acc_busy) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (poll_done_c) begin
                    if (enable) state_d = S_STAT_RD;
                    else        timer_d = timer_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STAT_RD: begin
                if (acc_busy) state_d = S_STAT_WAIT;
            end
            S_STAT_WAIT: begin
                if (acc_rvalid) begin
                    if (acc_rdata_c[WORDS_MSB:WORDS_LSB] >= WORDS_W'(MSG_WORDS)) begin
                        idx_d   = 2'd0;
                        state_d = S_MSG_RD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_MSG_RD: begin
                if (acc_busy) state_d = S_MSG_WAIT;
            end
            S_MSG_WAIT: begin
                if (acc_rvalid) begin
                    state_d = S_GAP;
                    case (idx_q)
                        2'd0: begin
                            // Bad header: drop the rest of the FIFO to resync
                            if (acc_rdata_c != MSG_ID) begin
                                if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
                                state_d = S_FLUSH;
                            end
                        end
                        2'd1: begin
                            box_d.left = acc_rdata_c[X_MSB:X_LSB];
                            box_d.top  = acc_rdata_c[Y_MSB:Y_LSB];
                        end
                        default: begin
                            box_d.right  = acc_rdata_c[X_MSB:X_LSB];
                            box_d.bottom = acc_rdata_c[Y_MSB:Y_LSB];
                        end
                    endcase
                end
            end
            S_GAP: begin
                if (idx_q == 2'd2) begin
                    box_valid_d = 1'b1;
                    box_empty_d = (box_q.left > box_q.right) || (box_q.top > box_q.bottom);
                    state_d     = S_OUT;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_MSG_RD;
                end
            end
            S_OUT: begin
                if (bus.box_ready) begin
                    msg_count_d = msg_count_q + 1'b1;
                    box_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_ID_RD;
            end
        endcase

        // Access matching the strobe state being entered (or re-tried after reset)
        if (!acc_busy) begin
            case (state_d)
                S_ID_RD: begin
                    acc_req_c  = 1'b1;
                    acc_addr_c = ADDR_ID;
                end
                S_STAT_RD: begin
                    acc_req_c  = 1'b1;
                    acc_addr_c = ADDR_STATUS;
                end
                S_MSG_RD: begin
                    acc_req_c  = 1'b1;
                    acc_addr_c = ADDR_MSG;
                end
                S_FLUSH: begin
                    acc_req_c   = 1'b1;
                    acc_we_c    = 1'b1;
                    acc_addr_c  = ADDR_STATUS;
                    acc_wdata_c = FLUSH_WORD;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_ID_RD;
            timer_q     <= '0;
            idx_q       <= '0;
            box_q       <= '0;
            box_valid_q <= 1'b0;
            box_empty_q <= 1'b0;
            msg_count_q <= '0;
            err_count_q <= '0;
            id_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            box_q       <= box_d;
            box_valid_q <= box_valid_d;
            box_empty_q <= box_empty_d;
            msg_count_q <= msg_count_d;
            err_count_q <= err_count_d;
            id_error_q  <= id_error_d;
        end
    end

    assign bus.box_valid  = box_valid_q;
    assign bus.box_left   = box_q.left;
    assign bus.box_top    = box_q.top;
    assign bus.box_right  = box_q.right;
    assign bus.box_bottom = box_q.bottom;
    assign bus.box_empty  = box_empty_q;
    assign msg_count      = msg_count_q;
    assign err_count      = err_count_q;
    assign id_error       = id_error_q;

endmodule

// File: tb/tb_bbox_msg_reader.sv
// Scoreboard bench for bbox_msg_reader: a slave model serves ID/status/FIFO
// reads, directed phases push expected writes and boxes into queues, and a
// monitor pops and compares them whenever the DUT presents them.
module tb_bbox_msg_reader;
    import bbox_msg_pkg::*;

    localparam int POLL = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] msg_count;
    logic [7:0]  err_count;
    logic        id_error;

    bbox_msg_reader_if bif();

    bbox_msg_reader #(
        .POLL_CYCLES (POLL),
        .EXPECT_ID   (32'h1234EEE2),
        .MSG_ID      (32'h00524242)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .bus       (bif),
        .msg_count (msg_count),
        .err_count (err_count),
        .id_error  (id_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: registers + message FIFO, data returned one cycle after the strobe
    logic [31:0] slave_fifo[$];
    logic [31:0] id_val = 32'h1234EEE2;

    always @(posedge clk) begin
        if (bif.m_read) begin
            case (bif.m_address)
                3'd0:    bif.m_readdata <= {16'h0, 8'(slave_fifo.size()), 8'h0};
                3'd1:    bif.m_readdata <= (slave_fifo.size() > 0) ? slave_fifo.pop_front() : 32'h0;
                3'd2:    bif.m_readdata <= id_val;
                default: bif.m_readdata <= 32'h0;
            endcase
        end else begin
            bif.m_readdata <= 32'hA5A5_A5A5;
        end
        if (bif.m_write && bif.m_address == 3'd0 && bif.m_writedata[4]) slave_fifo.delete();
    end

    // Scoreboards
    logic [34:0] exp_wr[$];   // {addr, data}
    logic [44:0] exp_box[$];  // {left, top, right, bottom, empty}

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   strobe_n = 0, msg_rd_n = 0, b2b_viol = 0, cs_viol = 0;
    int   stat_rd_cyc[$];
    int   last_stat_cyc = 0, lat = -1;
    logic prev_strobe = 1'b0, prev_bv = 1'b0;

    // Monitor: bus rules, write scoreboard, box scoreboard
    always @(negedge clk) begin
        if (bif.m_chipselect !== (bif.m_read | bif.m_write)) cs_viol++;
        if (!reset_n) begin
            prev_strobe = 1'b0;
            prev_bv     = 1'b0;
        end else begin
            if ((bif.m_read | bif.m_write) && prev_strobe) b2b_viol++;
            prev_strobe = bif.m_read | bif.m_write;
            if (bif.m_read | bif.m_write) strobe_n++;
            if (bif.m_read && bif.m_address == 3'd0) begin
                stat_rd_cyc.push_back(cyc);
                last_stat_cyc = cyc;
            end
            if (bif.m_read && bif.m_address == 3'd1) msg_rd_n++;
            if (bif.m_write) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 64'({bif.m_address, bif.m_writedata}), 64'(0));
                else chk("write", 64'({bif.m_address, bif.m_writedata}), 64'(exp_wr.pop_front()));
            end
            if (bif.box_valid && !prev_bv) lat = cyc - last_stat_cyc;
            prev_bv = bif.box_valid;
            if (bif.box_valid && bif.box_ready) begin
                if (exp_box.size() == 0)
                    chk("unexpected_box", 64'({bif.box_left, bif.box_top, bif.box_right, bif.box_bottom, bif.box_empty}), 64'(0));
                else
                    chk("box", 64'({bif.box_left, bif.box_top, bif.box_right, bif.box_bottom, bif.box_empty}),
                        64'(exp_box.pop_front()));
            end
        end
    end

    logic [10:0] sv_l, sv_t, sv_r, sv_b;
    logic        sv_e;
    int          base, viol;
    logic        seen;

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b1;
        bif.box_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_read",    64'(bif.m_read), 64'(0));
        chk("rst_m_write",   64'(bif.m_write), 64'(0));
        chk("rst_m_cs",      64'(bif.m_chipselect), 64'(0));
        chk("rst_box_valid", 64'(bif.box_valid), 64'(0));
        chk("rst_counts",    64'({msg_count, err_count, id_error}), 64'(0));

        // Good ID: one flush write, then periodic status polls
        exp_wr.push_back({3'd0, 32'h10});
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 10 * POLL && stat_rd_cyc.size() < 3; i++) @(negedge clk);
        chk("polls_seen", 64'(stat_rd_cyc.size() >= 3), 64'(1));
        if (stat_rd_cyc.size() >= 3) begin
            chk("poll_spacing_1", 64'(stat_rd_cyc[1] - stat_rd_cyc[0]), 64'(POLL + 2));
            chk("poll_spacing_2", 64'(stat_rd_cyc[2] - stat_rd_cyc[1]), 64'(POLL + 2));
        end
        chk("flush_after_id", 64'(exp_wr.size()), 64'(0));
        chk("id_error_good",  64'(id_error), 64'(0));
        chk("no_msg_reads",   64'(msg_rd_n), 64'(0));

        // Message with exactly 3 words
        @(posedge clk); #1;
        base = msg_rd_n;
        slave_fifo.push_back(32'h00524242);
        slave_fifo.push_back(32'h00640032);
        slave_fifo.push_back(32'h00C80096);
        exp_box.push_back({11'd100, 11'd50, 11'd200, 11'd150, 1'b0});
        bif.box_ready = 1'b1;
        for (int i = 0; i < 4 * POLL + 50 && msg_count != 16'd1; i++) @(negedge clk);
        chk("msg_count_1", 64'(msg_count), 64'(1));
        chk("latency",     64'(lat), 64'(11));
        chk("msg_reads_3", 64'(msg_rd_n - base), 64'(3));

        // Empty box (ignored bits set) held with box_ready low
        @(posedge clk); #1;
        bif.box_ready = 1'b0;
        slave_fifo.push_back(32'h00524242);
        slave_fifo.push_back(32'hFA7FF9DF);
        slave_fifo.push_back(32'h00000000);
        exp_box.push_back({11'd639, 11'd479, 11'd0, 11'd0, 1'b1});
        for (int i = 0; i < 4 * POLL + 50 && bif.box_valid !== 1'b1; i++) @(negedge clk);
        chk("box2_valid", 64'(bif.box_valid), 64'(1));
        sv_l = bif.box_left; sv_t = bif.box_top; sv_r = bif.box_right; sv_b = bif.box_bottom;
        sv_e = bif.box_empty;
        base = strobe_n;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (bif.box_valid !== 1'b1 || bif.box_left !== sv_l || bif.box_top !== sv_t ||
                bif.box_right !== sv_r || bif.box_bottom !== sv_b || bif.box_empty !== sv_e) viol++;
        end
        chk("hold_stable", 64'(viol), 64'(0));
        chk("hold_no_bus", 64'(strobe_n - base), 64'(0));
        @(posedge clk); #1 bif.box_ready = 1'b1;
        for (int i = 0; i < 10 && msg_count != 16'd2; i++) @(negedge clk);
        chk("msg_count_2", 64'(msg_count), 64'(2));

        // Bad header: error count, flush, then a good message
        @(posedge clk); #1;
        exp_wr.push_back({3'd0, 32'h10});
        slave_fifo.push_back(32'h00414141);
        slave_fifo.push_back(32'h00640032);
        slave_fifo.push_back(32'h00C80096);
        for (int i = 0; i < 4 * POLL + 50 && err_count != 8'd1; i++) @(negedge clk);
        chk("err_count_1", 64'(err_count), 64'(1));
        for (int i = 0; i < 20 && exp_wr.size() != 0; i++) @(negedge clk);
        chk("bad_hdr_flush", 64'(exp_wr.size()), 64'(0));
        chk("fifo_flushed",  64'(slave_fifo.size()), 64'(0));
        @(posedge clk); #1;
        slave_fifo.push_back(32'h00524242);
        slave_fifo.push_back(32'h000A0014);
        slave_fifo.push_back(32'h001E0028);
        exp_box.push_back({11'd10, 11'd20, 11'd30, 11'd40, 1'b0});
        for (int i = 0; i < 4 * POLL + 50 && msg_count != 16'd3; i++) @(negedge clk);
        chk("msg_count_3",    64'(msg_count), 64'(3));
        chk("err_count_hold", 64'(err_count), 64'(1));

        // Two words only: no message reads
        @(posedge clk); #1;
        base = msg_rd_n;
        slave_fifo.push_back(32'h00524242);
        slave_fifo.push_back(32'h00010001);
        repeat (4 * (POLL + 2)) @(negedge clk);
        chk("words2_no_read", 64'(msg_rd_n - base), 64'(0));
        chk("words2_fifo",    64'(slave_fifo.size()), 64'(2));

        // Reset in the middle of a message read
        slave_fifo.push_back(32'h00010002);
        seen = 1'b0;
        for (int i = 0; i < 4 * POLL + 50 && !seen; i++) begin
            @(negedge clk);
            seen = bif.m_read && bif.m_address == 3'd1;
        end
        chk("msg_read_seen", 64'(seen), 64'(1));
        reset_n = 1'b0;
        #1;
        chk("async_rst_read", 64'(bif.m_read), 64'(0));
        chk("async_rst_cs",   64'(bif.m_chipselect), 64'(0));
        exp_wr.push_back({3'd0, 32'h10});
        repeat (2) @(negedge clk);
        chk("rst_msg_count", 64'(msg_count), 64'(0));
        @(posedge clk); #1 reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bif.m_read | bif.m_write;
        end
        chk("restart_id_read", 64'({bif.m_read, bif.m_write, bif.m_address}), 64'({1'b1, 1'b0, 3'd2}));
        repeat (10) @(negedge clk);
        chk("restart_flush", 64'(exp_wr.size()), 64'(0));
        chk("resync_fifo",   64'(slave_fifo.size()), 64'(0));

        // Wrong ID: halt with no further traffic
        @(posedge clk); #1;
        reset_n = 1'b0;
        id_val  = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        base = strobe_n;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("id_error_set",   64'(id_error), 64'(1));
        chk("id_only_strobe", 64'(strobe_n - base), 64'(1));
        base = strobe_n;
        repeat (10000) @(negedge clk);
        chk("halt_no_bus",     64'(strobe_n - base), 64'(0));
        chk("id_error_sticky", 64'(id_error), 64'(1));

        chk("no_b2b_strobes", 64'(b2b_viol), 64'(0));
        chk("cs_matches",     64'(cs_viol), 64'(0));
        chk("boxes_drained",  64'(exp_box.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
